latch_bank_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for a small shared bank of D-type storage registers. Up to NREQ requesters compete for write access. The block grants one requester at a time and sequences its write through a fixed grant/write/done handshake. Reads are open to any consumer at all times. It sits between requester logic and the storage cells and owns both the arbitration state and the bank contents.

---
 rtl/lba_pkg.sv | 37 +++
 rtl/lba_storage.sv | 28 ++
 rtl/latch_bank_arbiter.sv | 121 ++++++++++++
 tb/tb_latch_bank_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lba_pkg.sv
// Shared types and helpers for latch_bank_arbiter: FSM state encoding and round-robin pick.
package lba_pkg;

  localparam int STATE_W = 2;
  localparam int MAX_REQ = 8;
  localparam int PICK_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // First asserted request at or after ptr, wrapping modulo nreq; 0 when nothing is asserted.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [PICK_W-1:0]  ptr,
                                                input int                 nreq);
    logic [PICK_W-1:0] win;
    logic              found;
    int                idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        idx = int'(ptr) + k;
        if (idx >= nreq) idx = idx - nreq;
        if (!found && req[idx[PICK_W-1:0]]) begin
          win   = idx[PICK_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/lba_storage.sv
// DEPTH x WIDTH register bank: async active-low clear, one write port, combinational read.
module lba_storage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin write arbiter/sequencer in front of a shared register bank.
// Optional read-during-write forwarding is enabled with `define LBA_BYPASS_EN.
import lba_pkg::*;

module latch_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_reg, state_next;
  logic [SW-1:0]    sel_reg, sel_next;
  logic [SW-1:0]    ptr_reg, ptr_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             we;
  logic [MAX_REQ-1:0] req_pad;
  logic [WIDTH-1:0] stored_rd;

  logic [AW-1:0]    addr_arr [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];

  // Unpack the flat per-requester buses and decode the one-hot grant/done outputs.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign addr_arr[gi] = wr_addr[gi*AW +: AW];
    assign data_arr[gi] = wr_data[gi*WIDTH +: WIDTH];
    assign gnt[gi]  = ((state_reg == GRANT) || (state_reg == WRITE)) && (sel_reg == SW'(gi));
    assign done[gi] = (state_reg == DONE) && (sel_reg == SW'(gi));
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    we         = 1'b0;
    req_pad    = '0;
    req_pad[NREQ-1:0] = req;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          sel_next   = SW'(rr_pick(req_pad, PICK_W'(ptr_reg), NREQ));
          state_next = GRANT;
        end
      end
      GRANT: begin
        // Requester withdrew before capture: abandon without touching ptr.
        if (req[sel_reg]) begin
          addr_next  = addr_arr[sel_reg];
          data_next  = data_arr[sel_reg];
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        we         = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        ptr_next   = (sel_reg == SW'(NREQ-1)) ? '0 : sel_reg + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  lba_storage #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_storage (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(addr_reg),
    .wdata(data_reg),
    .raddr(rd_addr),
    .rdata(stored_rd)
  );

`ifdef LBA_BYPASS_EN
  assign rd_data = ((state_reg == WRITE) && (rd_addr == addr_reg)) ? data_reg : stored_rd;
`else
  assign rd_data = stored_rd;
`endif

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Scoreboard bench for latch_bank_arbiter: expected grants queued at stimulus time, retired on done.
module tb_latch_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef LBA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*AW-1:0]    wr_addr = '0;
  logic [NREQ*WIDTH-1:0] wr_data = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [AW-1:0]         rd_addr = '0;
  logic [WIDTH-1:0]      rd_data;

  latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .done(done), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               idx;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } txn_t;

  txn_t             sb[$];
  logic [WIDTH-1:0] model [DEPTH];
  int               n_cmp = 0;
  int               n_fail = 0;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_addr[i*AW +: AW]       = a;
    wr_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic push(input int i);
    txn_t t;
    t.idx  = i;
    t.addr = wr_addr[i*AW +: AW];
    t.data = wr_data[i*WIDTH +: WIDTH];
    sb.push_back(t);
  endtask

  // Bounded wait for a done pulse, sampled on falling edges.
  task automatic wait_done(input int budget, output logic found, output int didx, output int at_cyc);
    found = 1'b0; didx = -1; at_cyc = -1;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (done !== '0) begin found = 1'b1; didx = onehot_idx(done); at_cyc = cyc; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt, done, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got gnt=%b done=%b busy=%b, want all 0", gnt, done, busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); #1;
      n_cmp++;
      if (rd_data !== '0) begin n_fail++; $display("FAIL reset_entry%0d: got %h want 00", a, rd_data); end
      model[a] = '0;
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic found; int didx, dc; txn_t e;
    set_req(0, 2'd2, 8'hA5); rd_addr = 2'd2; push(0); req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: got gnt=%b busy=%b want 0001/1", gnt, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt_write: got %b want 0001", gnt); end
    n_cmp++;
    if (rd_data !== (BYP ? 8'hA5 : 8'h00)) begin
      n_fail++; $display("FAIL single_rd_in_write: got %h want %h", rd_data, BYP ? 8'hA5 : 8'h00);
    end
    wait_done(1, found, didx, dc);
    e = sb.pop_front();
    n_cmp++;
    if (!found || didx != e.idx || gnt !== '0) begin
      n_fail++; $display("FAIL single_done: got idx %0d found=%0b gnt=%b want idx %0d gnt 0000", didx, found, gnt, e.idx);
    end else $display("txn single: req %0d addr %0d data %h done at cycle %0d", didx, e.addr, e.data, dc);
    model[e.addr] = e.data;
    req = '0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_data !== model[2]) begin
      n_fail++; $display("FAIL single_readback: got busy=%b rd=%h want 0/%h", busy, rd_data, model[2]);
    end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    set_req(2, 2'd1, 8'h77); req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rmw_pre: got gnt=%b want 0100", gnt); end
    rst = 1'b0; #1;
    n_cmp++;
    if ({gnt, done, busy} !== '0) begin
      n_fail++; $display("FAIL rmw_outputs: got gnt=%b done=%b busy=%b want 0", gnt, done, busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); #1;
      n_cmp++;
      if (rd_data !== '0) begin n_fail++; $display("FAIL rmw_entry%0d: got %h want 00", a, rd_data); end
      model[a] = '0;
    end
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (done !== '0 || busy !== 1'b0) seen++; end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL rmw_no_done: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_contention();
    logic found; int didx, dc, prev; txn_t e;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'h10 + 8'(i));
    push(0); push(1); push(2); push(3); push(0);
    req = 4'b1111;
    prev = 0;
    for (int t = 0; t < 5; t++) begin
      wait_done(4, found, didx, dc);
      e = sb.pop_front();
      n_cmp++;
      if (!found || didx != e.idx) begin
        n_fail++; $display("FAIL contention_order%0d: got idx %0d found=%0b want %0d", t, didx, found, e.idx);
      end else $display("txn contention: req %0d addr %0d data %h done at cycle %0d", didx, e.addr, e.data, dc);
      if (t > 0) begin
        n_cmp++;
        if (dc - prev != 4) begin n_fail++; $display("FAIL contention_spacing%0d: got %0d want 4", t, dc - prev); end
      end
      prev = dc;
      model[e.addr] = e.data;
      if (t == 4) req = '0;
    end
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); #1;
      n_cmp++;
      if (rd_data !== model[a]) begin n_fail++; $display("FAIL contention_entry%0d: got %h want %h", a, rd_data, model[a]); end
    end
  endtask

  task automatic test_abort();
    logic found; int didx, dc, seen; txn_t e;
    set_req(1, 2'd1, 8'hEE); req = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_grant: got %b want 0010", gnt); end
    req = '0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_release: got gnt=%b busy=%b want 0/0", gnt, busy); end
    seen = 0;
    repeat (4) begin @(negedge clk); if (done !== '0) seen++; end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    rd_addr = 2'd1; #1;
    n_cmp++;
    if (rd_data !== model[1]) begin n_fail++; $display("FAIL abort_entry: got %h want %h", rd_data, model[1]); end
    // With the pointer still at 1, requester 1 must beat requester 0.
    push(1); req = 4'b0011;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_ptr: got gnt=%b want 0010", gnt); end
    wait_done(3, found, didx, dc);
    e = sb.pop_front();
    n_cmp++;
    if (!found || didx != e.idx) begin
      n_fail++; $display("FAIL abort_retry_done: got idx %0d found=%0b want %0d", didx, found, e.idx);
    end else $display("txn abort-retry: req %0d addr %0d data %h done at cycle %0d", didx, e.addr, e.data, dc);
    model[e.addr] = e.data;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic found; int didx, dc; txn_t e;
    set_req(0, 2'd0, 8'h50); push(0); req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL fair_first: got %b want 0001", gnt); end
    set_req(2, 2'd2, 8'h52); push(2); push(0); req = 4'b0101;
    for (int t = 0; t < 3; t++) begin
      wait_done(6, found, didx, dc);
      e = sb.pop_front();
      n_cmp++;
      if (!found || didx != e.idx) begin
        n_fail++; $display("FAIL fair_order%0d: got idx %0d found=%0b want %0d", t, didx, found, e.idx);
      end else $display("txn fairness: req %0d addr %0d data %h done at cycle %0d", didx, e.addr, e.data, dc);
      model[e.addr] = e.data;
      if (t == 1) req = 4'b0001;
      if (t == 2) req = '0;
    end
    @(negedge clk);
    rd_addr = 2'd2; #1;
    n_cmp++;
    if (rd_data !== model[2]) begin n_fail++; $display("FAIL fair_entry2: got %h want %h", rd_data, model[2]); end
  endtask

  task automatic test_bypass();
    logic found; int didx, dc; txn_t e; logic [WIDTH-1:0] old_v;
    rd_addr = 2'd3;
    old_v = model[3];
    set_req(3, 2'd3, 8'h3C); push(3); req = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (rd_data !== old_v) begin n_fail++; $display("FAIL bypass_grant_rd: got %h want %h", rd_data, old_v); end
    @(negedge clk);
    n_cmp++;
    if (rd_data !== (BYP ? 8'h3C : old_v)) begin
      n_fail++; $display("FAIL bypass_write_rd: got %h want %h", rd_data, BYP ? 8'h3C : old_v);
    end
    wait_done(1, found, didx, dc);
    e = sb.pop_front();
    n_cmp++;
    if (!found || didx != e.idx) begin
      n_fail++; $display("FAIL bypass_done: got idx %0d found=%0b want %0d", didx, found, e.idx);
    end else $display("txn bypass: req %0d addr %0d data %h done at cycle %0d", didx, e.addr, e.data, dc);
    model[e.addr] = e.data;
    req = '0;
    n_cmp++;
    if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL bypass_after: got %h want 3c", rd_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_write();
    test_contention();
    test_abort();
    test_fairness();
    test_bypass();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
